// File: rtl/raster_types.sv
// Shared types for the raster CSR bank.
// Holds the CSR parameter struct, the CSR field indices and the per-slot state enum.
package raster_types;

    typedef struct packed {
        logic [31:0] pidx_addr;
        logic [31:0] pidx_size;
        logic [31:0] pbuf_addr;
        logic [31:0] pbuf_stride;
        logic [15:0] tile_left;
        logic [15:0] tile_top;
        logic [15:0] tile_width;
        logic [15:0] tile_height;
    } raster_csrs_t;

    localparam logic [2:0] CsrPidxAddr   = 3'd0;
    localparam logic [2:0] CsrPidxSize   = 3'd1;
    localparam logic [2:0] CsrPbufAddr   = 3'd2;
    localparam logic [2:0] CsrPbufStride = 3'd3;
    localparam logic [2:0] CsrTileLeft   = 3'd4;
    localparam logic [2:0] CsrTileTop    = 3'd5;
    localparam logic [2:0] CsrTileWidth  = 3'd6;
    localparam logic [2:0] CsrTileHeight = 3'd7;

    typedef enum logic [1:0] {
        SlotIdle    = 2'd0,
        SlotPending = 2'd1,
        SlotIssued  = 2'd2
    } slot_state_t;

endpackage

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   requests     one request bit per requester
//   grant_take   the current grant is consumed this cycle; advances the pointer
//   grant_valid  at least one request is present
//   grant_index  index of the granted requester
// The search starts at the requester after the last consumed grant.
module VX_rr_arbiter #(
    parameter int unsigned NUM_REQS = 2,
    parameter int unsigned IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                grant_take,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_index
);

    logic [IDX_BITS-1:0] ptr_q;
    logic [31:0]         cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!grant_valid && requests[IDX_BITS'(cand)]) begin
                grant_valid = 1'b1;
                grant_index = IDX_BITS'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (grant_take && grant_valid) begin
            ptr_q <= (32'(grant_index) == NUM_REQS - 1) ? '0 : grant_index + 1'b1;
        end
    end

endmodule

// File: rtl/raster_csr_bank.sv
// Multi-slot double-buffered CSR bank for the raster unit.
// Software writes per-slot shadow registers and commits a slot; the commit snapshots the
// shadow set into the active set and the slot is issued as a job, round-robin among
// pending slots.
// Ports:
//   clk, reset                     clock and asynchronous active-high reset
//   csr_wr_*                       shadow register write (slot, field index, data)
//   commit_valid/slot/ready        commit request; ready is combinational (slot IDLE)
//   job_valid/ready/slot/csrs      registered job output, valid/ready handshake
//   done_valid/slot                job completion from the consumer
//   slot_busy                      per-slot not-IDLE flags
//   err                            sticky flag: done for a slot that was not ISSUED
module raster_csr_bank
    import raster_types::*;
#(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned COORD_BITS = 16,
    parameter int unsigned SLOT_BITS  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_wr_valid,
    input  logic [SLOT_BITS-1:0] csr_wr_slot,
    input  logic [2:0]           csr_wr_idx,
    input  logic [31:0]          csr_wr_data,
    input  logic                 commit_valid,
    input  logic [SLOT_BITS-1:0] commit_slot,
    output logic                 commit_ready,
    output logic                 job_valid,
    input  logic                 job_ready,
    output logic [SLOT_BITS-1:0] job_slot,
    output raster_csrs_t         job_csrs,
    input  logic                 done_valid,
    input  logic [SLOT_BITS-1:0] done_slot,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 err
);

    localparam logic [15:0] CoordMask = 16'((33'd1 << COORD_BITS) - 33'd1);

    raster_csrs_t shadow_q [NUM_SLOTS];
    raster_csrs_t shadow_d [NUM_SLOTS];
    raster_csrs_t active_q [NUM_SLOTS];
    raster_csrs_t active_d [NUM_SLOTS];
    slot_state_t  state_q  [NUM_SLOTS];
    slot_state_t  state_d  [NUM_SLOTS];
    logic         err_q, err_d;

    logic                 job_valid_q, job_valid_d;
    logic [SLOT_BITS-1:0] job_slot_q, job_slot_d;
    raster_csrs_t         job_csrs_q, job_csrs_d;

    logic                 commit_fire, commit_nonzero, handshake, out_load;
    logic [NUM_SLOTS-1:0] requests;
    logic                 grant_valid;
    logic [SLOT_BITS-1:0] grant_index;
    logic [15:0]          coord_data;

    function automatic logic slot_ok(logic [SLOT_BITS-1:0] s);
        return 32'(s) < NUM_SLOTS;
    endfunction

    assign commit_ready   = slot_ok(commit_slot) && (state_q[commit_slot] == SlotIdle);
    assign commit_fire    = commit_valid && commit_ready;
    // Judged on the pre-write shadow, the same copy the snapshot takes.
    assign commit_nonzero = (shadow_q[commit_slot].tile_width != '0) &&
                            (shadow_q[commit_slot].tile_height != '0);
    assign handshake      = job_valid_q && job_ready;
    // The output stage reloads when empty or when its job is being taken.
    assign out_load       = !job_valid_q || job_ready;
    assign coord_data     = csr_wr_data[15:0] & CoordMask;

    // A slot committed this cycle requests immediately so its job appears next cycle;
    // the slot currently on the output is excluded so it is never granted twice.
    always_comb begin
        requests = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            requests[s] = ((state_q[s] == SlotPending) &&
                           !(job_valid_q && (job_slot_q == SLOT_BITS'(s)))) ||
                          (commit_fire && commit_nonzero && (commit_slot == SLOT_BITS'(s)));
        end
    end

    VX_rr_arbiter #(
        .NUM_REQS (NUM_SLOTS),
        .IDX_BITS (SLOT_BITS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (requests),
        .grant_take  (out_load),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        state_d     = state_q;
        err_d       = err_q;
        job_valid_d = job_valid_q;
        job_slot_d  = job_slot_q;
        job_csrs_d  = job_csrs_q;

        if (csr_wr_valid && slot_ok(csr_wr_slot)) begin
            unique case (csr_wr_idx)
                CsrPidxAddr:   shadow_d[csr_wr_slot].pidx_addr   = csr_wr_data;
                CsrPidxSize:   shadow_d[csr_wr_slot].pidx_size   = csr_wr_data;
                CsrPbufAddr:   shadow_d[csr_wr_slot].pbuf_addr   = csr_wr_data;
                CsrPbufStride: shadow_d[csr_wr_slot].pbuf_stride = csr_wr_data;
                CsrTileLeft:   shadow_d[csr_wr_slot].tile_left   = coord_data;
                CsrTileTop:    shadow_d[csr_wr_slot].tile_top    = coord_data;
                CsrTileWidth:  shadow_d[csr_wr_slot].tile_width  = coord_data;
                CsrTileHeight: shadow_d[csr_wr_slot].tile_height = coord_data;
                default:       ;
            endcase
        end

        if (commit_fire) begin
            active_d[commit_slot] = shadow_q[commit_slot];
            if (commit_nonzero) begin
                state_d[commit_slot] = SlotPending;
            end
        end

        if (handshake) begin
            state_d[job_slot_q] = SlotIssued;
        end

        if (done_valid) begin
            if (slot_ok(done_slot) && (state_q[done_slot] == SlotIssued)) begin
                state_d[done_slot] = SlotIdle;
            end else begin
                err_d = 1'b1;
            end
        end

        if (out_load) begin
            job_valid_d = grant_valid;
            if (grant_valid) begin
                job_slot_d = grant_index;
                job_csrs_d = active_d[grant_index];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
                state_q[s]  <= SlotIdle;
            end
            err_q       <= 1'b0;
            job_valid_q <= 1'b0;
            job_slot_q  <= '0;
            job_csrs_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            state_q     <= state_d;
            err_q       <= err_d;
            job_valid_q <= job_valid_d;
            job_slot_q  <= job_slot_d;
            job_csrs_q  <= job_csrs_d;
        end
    end

    always_comb begin
        slot_busy = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            slot_busy[s] = (state_q[s] != SlotIdle);
        end
    end

    assign job_valid = job_valid_q;
    assign job_slot  = job_slot_q;
    assign job_csrs  = job_csrs_q;
    assign err       = err_q;

endmodule

// File: tb/tb_raster_csr_bank.sv
// Self-checking bench for raster_csr_bank (2 slots, 8-bit coordinates).
// A field-array model predicts every output each cycle; directed literals pin the model.
module tb_raster_csr_bank;
    import raster_types::*;

    localparam int unsigned NS = 2;
    localparam int unsigned CB = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         csr_wr_valid = 1'b0;
    logic [0:0]   csr_wr_slot = '0;
    logic [2:0]   csr_wr_idx = '0;
    logic [31:0]  csr_wr_data = '0;
    logic         commit_valid = 1'b0;
    logic [0:0]   commit_slot = '0;
    logic         commit_ready;
    logic         job_valid;
    logic         job_ready = 1'b0;
    logic [0:0]   job_slot;
    raster_csrs_t job_csrs;
    logic         done_valid = 1'b0;
    logic [0:0]   done_slot = '0;
    logic [NS-1:0] slot_busy;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    raster_csr_bank #(
        .NUM_SLOTS  (NS),
        .COORD_BITS (CB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_slot  (csr_wr_slot),
        .csr_wr_idx   (csr_wr_idx),
        .csr_wr_data  (csr_wr_data),
        .commit_valid (commit_valid),
        .commit_slot  (commit_slot),
        .commit_ready (commit_ready),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_slot     (job_slot),
        .job_csrs     (job_csrs),
        .done_valid   (done_valid),
        .done_slot    (done_slot),
        .slot_busy    (slot_busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slot states: 0 idle, 1 pending, 2 issued. Fields held as 8 words per slot.
    logic [31:0] m_shadow [NS][8];
    logic [31:0] m_active [NS][8];
    int          m_state  [NS];
    int          m_ptr;
    bit          m_jv;
    int          m_js;
    bit          m_err;

    function automatic raster_csrs_t model_job(int s);
        raster_csrs_t r;
        r.pidx_addr   = m_active[s][0];
        r.pidx_size   = m_active[s][1];
        r.pbuf_addr   = m_active[s][2];
        r.pbuf_stride = m_active[s][3];
        r.tile_left   = 16'(m_active[s][4]);
        r.tile_top    = 16'(m_active[s][5]);
        r.tile_width  = 16'(m_active[s][6]);
        r.tile_height = 16'(m_active[s][7]);
        return r;
    endfunction

    int old_state [NS];
    bit hs, acc;
    int cs, cand;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                for (int f = 0; f < 8; f++) begin
                    m_shadow[s][f] = '0;
                    m_active[s][f] = '0;
                end
                m_state[s] = 0;
            end
            m_ptr = 0; m_jv = 0; m_js = 0; m_err = 0;
        end else begin
            old_state = m_state;
            hs  = m_jv && job_ready;
            cs  = int'(commit_slot);
            acc = commit_valid && (old_state[cs] == 0);
            if (hs) m_state[m_js] = 2;
            if (done_valid) begin
                if (old_state[int'(done_slot)] == 2) m_state[int'(done_slot)] = 0;
                else m_err = 1;
            end
            if (acc) begin
                for (int f = 0; f < 8; f++) m_active[cs][f] = m_shadow[cs][f];
                if (m_shadow[cs][6] != 0 && m_shadow[cs][7] != 0) m_state[cs] = 1;
            end
            if (csr_wr_valid)
                m_shadow[int'(csr_wr_slot)][int'(csr_wr_idx)] =
                    (csr_wr_idx >= 3'd4) ? (csr_wr_data & ((32'd1 << CB) - 1)) : csr_wr_data;
            if (!m_jv || hs) begin
                m_jv = 0;
                for (int k = 0; k < NS; k++) begin
                    cand = (m_ptr + k) % NS;
                    if (!m_jv && m_state[cand] == 1) begin
                        m_jv = 1;
                        m_js = cand;
                    end
                end
                if (m_jv) m_ptr = (m_js + 1) % NS;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("job_valid", 192'(job_valid), 192'(m_jv));
            if (m_jv) begin
                chk("job_slot", 192'(job_slot), 192'(m_js));
                chk("job_csrs", job_csrs, model_job(m_js));
            end
            chk("slot_busy", 192'(slot_busy), 192'({m_state[1] != 0, m_state[0] != 0}));
            chk("err", 192'(err), 192'(m_err));
            chk("commit_ready", 192'(commit_ready), 192'(m_state[int'(commit_slot)] == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int s, input int idx, input logic [31:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_slot  = 1'(s);
        csr_wr_idx   = 3'(idx);
        csr_wr_data  = d;
        tick();
        csr_wr_valid = 1'b0;
    endtask

    task automatic commit(input int s);
        commit_valid = 1'b1;
        commit_slot  = 1'(s);
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic done(input int s);
        done_valid = 1'b1;
        done_slot  = 1'(s);
        tick();
        done_valid = 1'b0;
    endtask

    task automatic take();
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_job_valid", 192'(job_valid), 192'(0));
        chk("rst_job_csrs", job_csrs, 192'(0));
        chk("rst_slot_busy", 192'(slot_busy), 192'(0));
        chk("rst_err", 192'(err), 192'(0));
        reset = 1'b0;
        started = 1'b1;
        tick();

        // Basic job, held under backpressure
        wr(0, 0, 32'h1000);
        wr(0, 4, 8);
        wr(0, 5, 16);
        wr(0, 6, 32);
        wr(0, 7, 32);
        commit(0);
        chk("t1_valid", 192'(job_valid), 192'(1));
        chk("t1_slot", 192'(job_slot), 192'(0));
        chk("t1_pidx", 192'(job_csrs.pidx_addr), 192'(32'h1000));
        chk("t1_tile", 192'({job_csrs.tile_left, job_csrs.tile_top, job_csrs.tile_width,
                             job_csrs.tile_height}), 192'(64'h0008_0010_0020_0020));
        chk("t1_busy", 192'(slot_busy), 192'(2'b01));
        for (int i = 0; i < 5; i++) tick();
        chk("t1_hold_valid", 192'(job_valid), 192'(1));
        chk("t1_hold_width", 192'(job_csrs.tile_width), 192'(32));
        take();
        chk("t1_after_hs", 192'(job_valid), 192'(0));
        done(0);
        chk("t1_idle", 192'(slot_busy), 192'(0));

        // Back-to-back jobs, slots 0 then 1
        wr(1, 0, 32'h2000);
        wr(1, 6, 16);
        wr(1, 7, 16);
        job_ready = 1'b1;
        commit_valid = 1'b1;
        commit_slot  = 1'b0;
        tick();
        chk("t2_first", 192'(job_slot), 192'(0));
        commit_slot = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("t2_second_valid", 192'(job_valid), 192'(1));
        chk("t2_second", 192'(job_slot), 192'(1));
        chk("t2_second_pidx", 192'(job_csrs.pidx_addr), 192'(32'h2000));
        tick();
        job_ready = 1'b0;
        chk("t2_drained", 192'(job_valid), 192'(0));
        done(0);
        done(1);

        // Same-cycle write and commit: job sees the pre-write width
        csr_wr_valid = 1'b1;
        csr_wr_slot  = 1'b0;
        csr_wr_idx   = 3'd6;
        csr_wr_data  = 32'd64;
        commit_valid = 1'b1;
        commit_slot  = 1'b0;
        tick();
        csr_wr_valid = 1'b0;
        commit_valid = 1'b0;
        chk("t3_old_width", 192'(job_csrs.tile_width), 192'(32));
        take();
        done(0);
        commit(0);
        chk("t3_new_width", 192'(job_csrs.tile_width), 192'(64));
        take();
        done(0);

        // Zero-area commit is accepted but issues nothing
        wr(1, 7, 0);
        commit(1);
        chk("t4_no_job", 192'(job_valid), 192'(0));
        chk("t4_not_busy", 192'(slot_busy), 192'(0));

        // Stray done sets sticky err; slot 1 stays busy until its own done
        wr(1, 7, 16);
        commit(1);
        chk("t5_slot", 192'(job_slot), 192'(1));
        take();
        done(0);
        chk("t5_err", 192'(err), 192'(1));
        chk("t5_busy", 192'(slot_busy), 192'(2'b10));
        tick();
        tick();
        chk("t5_err_sticky", 192'(err), 192'(1));
        done_valid   = 1'b1;
        done_slot    = 1'b1;
        commit_valid = 1'b1;
        commit_slot  = 1'b1;
        #1;
        chk("t5_cr_same_cycle", 192'(commit_ready), 192'(0));
        tick();
        done_valid   = 1'b0;
        commit_valid = 1'b0;
        chk("t5_freed", 192'(slot_busy), 192'(0));
        chk("t5_rejected", 192'(job_valid), 192'(0));
        chk("t5_cr_free", 192'(commit_ready), 192'(1));

        // Coordinate truncation, then reset in the middle of a job
        wr(0, 4, 32'h1234);
        commit(0);
        chk("t6_left", 192'(job_csrs.tile_left), 192'(16'h0034));
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 192'(job_valid), 192'(0));
        chk("t6_rst_slot", 192'(job_slot), 192'(0));
        chk("t6_rst_csrs", job_csrs, 192'(0));
        chk("t6_rst_busy", 192'(slot_busy), 192'(0));
        chk("t6_rst_err", 192'(err), 192'(0));
        tick();
        reset = 1'b0;
        tick();
        commit(0);
        chk("t6_shadow_cleared", 192'(job_valid), 192'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
